uart_rx_frame: RTL

UART receive-side frame engine, the counterpart of the transmit path in the UART-to-APB bridge. It oversamples the serial line and detects the start bit. It then recovers DATA_WIDTH data bits LSB-first, checks an optional parity bit and one stop bit, and presents the parallel byte with a one-cycle valid strobe. The output feeds the bridge's command parser.

---
 rtl/uart_rx_frame.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Purpose  : UART receive frame engine. Oversamples the serial line,
//            qualifies the start bit, recovers DATA_WIDTH data bits LSB-first,
//            checks an optional parity bit and one stop bit, then presents the
//            received word with a one-cycle valid strobe.
// Ports    : CLK        system clock
//            RST        asynchronous active-low reset
//            rx_en      oversample tick enable (all counting gated by it)
//            RX_IN      serial line, asynchronous, idle high
//            PAR_EN     parity bit present (latched at start detection)
//            PAR_TYP    0 = even, 1 = odd parity (latched at start detection)
//            P_DATA     last good received word
//            Data_Valid one-cycle pulse when P_DATA is updated
//            Par_Err    one-cycle pulse on parity mismatch
//            Stp_Err    one-cycle pulse when the stop bit samples 0
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_en,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    localparam int EDGE_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(OVERSAMPLE - 1);
    localparam logic [EDGE_W-1:0] SMP_LO    = EDGE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [EDGE_W-1:0] SMP_MID   = EDGE_W'(OVERSAMPLE / 2);
    localparam logic [EDGE_W-1:0] SMP_HI    = EDGE_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state, state_n;
    logic                  sync_q, rx_s;
    logic [EDGE_W-1:0]     edge_cnt, edge_n;
    logic [BIT_W-1:0]      bit_cnt, bit_n;
    logic [DATA_WIDTH-1:0] shift_reg, shift_n;
    logic                  samp_lo, samp_lo_n;
    logic                  samp_mid, samp_mid_n;
    logic                  par_bad, par_bad_n;
    logic                  par_en_lat, par_en_n;
    logic                  par_typ_lat, par_typ_n;
    logic                  eval;
    logic                  majority;
    logic                  at_wrap;
    logic                  at_smp;
    logic                  stop_fail;
    logic                  par_fail;
    logic                  frame_ok;

    // The third vote is the live synchronized line on the sample-point tick.
    assign majority = (samp_lo & samp_mid) | (samp_lo & rx_s) | (samp_mid & rx_s);
    assign at_wrap  = (edge_cnt == EDGE_LAST);
    assign at_smp   = (edge_cnt == SMP_HI);

    assign stop_fail = eval & ~majority;
    assign par_fail  = eval & par_en_lat & par_bad;
    assign frame_ok  = eval & ~stop_fail & ~par_fail;

    always_comb begin
        state_n    = state;
        edge_n     = edge_cnt;
        bit_n      = bit_cnt;
        shift_n    = shift_reg;
        samp_lo_n  = samp_lo;
        samp_mid_n = samp_mid;
        par_bad_n  = par_bad;
        par_en_n   = par_en_lat;
        par_typ_n  = par_typ_lat;
        eval       = 1'b0;

        if (rx_en) begin
            if (state == IDLE) begin
                if (!rx_s) begin
                    state_n   = START;
                    edge_n    = '0;
                    bit_n     = '0;
                    par_bad_n = 1'b0;
                    par_en_n  = PAR_EN;
                    par_typ_n = PAR_TYP;
                end
            end else begin
                edge_n = at_wrap ? '0 : edge_cnt + 1'b1;
                if (edge_cnt == SMP_LO) begin
                    samp_lo_n = rx_s;
                end
                if (edge_cnt == SMP_MID) begin
                    samp_mid_n = rx_s;
                end

                case (state)
                    START: begin
                        if (at_smp && majority) begin
                            // Start bit did not hold low: treat as a glitch.
                            state_n = IDLE;
                            edge_n  = '0;
                        end else if (at_wrap) begin
                            state_n = DATA;
                            bit_n   = '0;
                        end
                    end
                    DATA: begin
                        if (at_smp) begin
                            shift_n = DATA_WIDTH'({majority, shift_reg} >> 1);
                        end
                        if (at_wrap) begin
                            if (bit_cnt == BIT_LAST) begin
                                bit_n   = '0;
                                state_n = par_en_lat ? PARITY : STOP;
                            end else begin
                                bit_n = bit_cnt + 1'b1;
                            end
                        end
                    end
                    PARITY: begin
                        if (at_smp) begin
                            par_bad_n = majority ^ (^shift_reg) ^ par_typ_lat;
                        end
                        if (at_wrap) begin
                            state_n = STOP;
                        end
                    end
                    STOP: begin
                        // Leave on the sample point so a back-to-back start
                        // edge in the second half of the stop bit is caught.
                        if (at_smp) begin
                            eval    = 1'b1;
                            state_n = IDLE;
                            edge_n  = '0;
                            bit_n   = '0;
                        end
                    end
                    default: begin
                        state_n = IDLE;
                        edge_n  = '0;
                        bit_n   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q      <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            samp_lo     <= 1'b0;
            samp_mid    <= 1'b0;
            par_bad     <= 1'b0;
            par_en_lat  <= 1'b0;
            par_typ_lat <= 1'b0;
            P_DATA      <= '0;
            Data_Valid  <= 1'b0;
            Par_Err     <= 1'b0;
            Stp_Err     <= 1'b0;
        end else begin
            sync_q      <= RX_IN;
            rx_s        <= sync_q;
            state       <= state_n;
            edge_cnt    <= edge_n;
            bit_cnt     <= bit_n;
            shift_reg   <= shift_n;
            samp_lo     <= samp_lo_n;
            samp_mid    <= samp_mid_n;
            par_bad     <= par_bad_n;
            par_en_lat  <= par_en_n;
            par_typ_lat <= par_typ_n;
            Data_Valid  <= frame_ok;
            Par_Err     <= par_fail;
            Stp_Err     <= stop_fail;
            if (frame_ok) begin
                P_DATA <= shift_reg;
            end
        end
    end

endmodule
`default_nettype wire
